// File: rtl/wisc_pkg.sv
// Shared WISC constants and the HALT opcode decode used by the fetch stage.
package wisc_pkg;

    localparam int INSTR_W    = 16;
    localparam int REG_ADDR_W = 3;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0800;
    localparam logic [4:0]         HALT_OP   = 5'b00000;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[15:11] == HALT_OP;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: hold keeps contents, load_nop inserts a bubble.
module ifid_reg
    import wisc_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic               load_nop,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic [PC_W-1:0]    pc_inc_d,
    output logic [INSTR_W-1:0] instr_q,
    output logic [PC_W-1:0]    pc_inc_q,
    output logic               valid_q
);

    // load_nop wins over hold so a redirect can flush a stalled slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q  <= NOP_INSTR;
            pc_inc_q <= '0;
            valid_q  <= 1'b0;
        end else if (load_nop) begin
            instr_q  <= NOP_INSTR;
            pc_inc_q <= '0;
            valid_q  <= 1'b0;
        end else if (!hold) begin
            instr_q  <= instr_d;
            pc_inc_q <= pc_inc_d;
            valid_q  <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_ifid.sv
// WISC fetch stage: PC, next-PC mux, HALT freeze and IF/ID register.
// FETCH_IMEM_WAIT_EN adds imem_ready and fetch-wait bubbles.
module fetch_ifid
    import wisc_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stallCtrl,
    input  logic                  Branch_EXMEM,
    input  logic [PC_W-1:0]       target_EXMEM,
    output logic [PC_W-1:0]       imem_addr,
    input  logic [INSTR_W-1:0]    imem_data,
`ifdef FETCH_IMEM_WAIT_EN
    input  logic                  imem_ready,
`endif
    output logic [INSTR_W-1:0]    instr_IFID,
    output logic [PC_W-1:0]       pcInc_IFID,
    output logic                  valid_IFID,
    output logic [REG_ADDR_W-1:0] Rd1_IFID,
    output logic [REG_ADDR_W-1:0] Rd2_IFID,
    output logic                  halted
);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_inc;
    logic            ready;
    logic            fetch;
    logic            bubble;
    logic            halt_pending;

`ifdef FETCH_IMEM_WAIT_EN
    assign ready = imem_ready;
`else
    assign ready = 1'b1;
`endif

    assign pc_inc = pc + PC_W'(2);
    assign fetch  = !Branch_EXMEM && !stallCtrl && ready && !halt_pending;
    assign bubble = Branch_EXMEM || (!stallCtrl && (!ready || halt_pending));

    always_comb begin
        pc_next = pc;
        unique case (1'b1)
            Branch_EXMEM: pc_next = target_EXMEM;
            fetch:        pc_next = pc_inc;
            default:      pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc <= RESET_PC;
        else      pc <= pc_next;
    end

    // a redirect cancels a HALT fetched down the wrong path
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            halt_pending <= 1'b0;
        else if (Branch_EXMEM)
            halt_pending <= 1'b0;
        else if (fetch && is_halt(imem_data))
            halt_pending <= 1'b1;
    end

    ifid_reg #(.PC_W(PC_W)) u_ifid (
        .clk      (clk),
        .rst      (rst),
        .hold     (stallCtrl),
        .load_nop (bubble),
        .instr_d  (imem_data),
        .pc_inc_d (pc_inc),
        .instr_q  (instr_IFID),
        .pc_inc_q (pcInc_IFID),
        .valid_q  (valid_IFID)
    );

    assign imem_addr = pc;
    assign halted    = halt_pending;
    assign Rd1_IFID  = instr_IFID[10:8];
    assign Rd2_IFID  = instr_IFID[7:5];

endmodule

// File: tb/tb_fetch_ifid.sv
// Bench for fetch_ifid: directed table, hand sequences, random vs model.
module tb_fetch_ifid;

`ifdef FETCH_IMEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stallCtrl;
    logic        Branch_EXMEM;
    logic [15:0] target_EXMEM;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_ready;
    logic [15:0] instr_IFID;
    logic [15:0] pcInc_IFID;
    logic        valid_IFID;
    logic [2:0]  Rd1_IFID;
    logic [2:0]  Rd2_IFID;
    logic        halted;

    int n_vec = 0;
    int n_bad = 0;

    logic        use_rnd;
    logic        halt_on;
    logic [15:0] halt_addr;
    logic [15:0] rnd_mem [256];

    always #5 clk = ~clk;

    fetch_ifid #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallCtrl    (stallCtrl),
        .Branch_EXMEM (Branch_EXMEM),
        .target_EXMEM (target_EXMEM),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
`ifdef FETCH_IMEM_WAIT_EN
        .imem_ready   (imem_ready),
`endif
        .instr_IFID   (instr_IFID),
        .pcInc_IFID   (pcInc_IFID),
        .valid_IFID   (valid_IFID),
        .Rd1_IFID     (Rd1_IFID),
        .Rd2_IFID     (Rd2_IFID),
        .halted       (halted)
    );

    function automatic logic [15:0] fw(input logic [15:0] a);
        return 16'h4000 | {a[8:1], 8'h00} | {8'h00, a[15:8]};
    endfunction

    always_comb begin
        if (use_rnd)
            imem_data = rnd_mem[imem_addr[8:1]];
        else if (halt_on && imem_addr == halt_addr)
            imem_data = 16'h0000;
        else
            imem_data = fw(imem_addr);
    end

    typedef struct {
        string       nm;
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic [15:0] addr;
        logic [15:0] instr;
        logic [15:0] pcinc;
        logic        valid;
        logic        hlt;
    } vec_t;

    vec_t tbl [9];

    function automatic vec_t mk(string nm, logic s, logic b, logic [15:0] t,
                                logic [15:0] a, logic [15:0] i,
                                logic [15:0] p, logic v, logic h);
        vec_t r;
        r.nm = nm; r.stall = s; r.br = b; r.tgt = t;
        r.addr = a; r.instr = i; r.pcinc = p; r.valid = v; r.hlt = h;
        return r;
    endfunction

    task automatic check(input string nm, input logic [15:0] ea,
                         input logic [15:0] ei, input logic [15:0] ep,
                         input logic ev, input logic eh, input logic chk_p);
        logic [15:0] e;
        e = ei;
        n_vec++;
        if (imem_addr !== ea || instr_IFID !== ei ||
            (chk_p && pcInc_IFID !== ep) || valid_IFID !== ev ||
            halted !== eh || Rd1_IFID !== e[10:8] || Rd2_IFID !== e[7:5]) begin
            n_bad++;
            $display("FAIL %s: got addr=%h instr=%h pcinc=%h v=%b h=%b rd=%0d/%0d need addr=%h instr=%h pcinc=%h v=%b h=%b",
                     nm, imem_addr, instr_IFID, pcInc_IFID, valid_IFID, halted,
                     Rd1_IFID, Rd2_IFID, ea, ei, ep, ev, eh);
        end
    endtask

    task automatic drive(input logic s, input logic b,
                         input logic [15:0] t, input logic r);
        stallCtrl    = s;
        Branch_EXMEM = b;
        target_EXMEM = t;
        imem_ready   = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b0;
        drive(0, 0, 16'h0, 1);
        #1;
        check(nm, 16'h0000, 16'h0800, 16'h0000, 0, 0, 1);
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [15:0] m_pc, m_instr, m_pcinc, d;
    logic        m_valid, m_halt, s, b, r;
    logic [15:0] t;

    initial begin
        use_rnd = 0; halt_on = 0; halt_addr = 16'h0;
        rst = 1'b0;
        drive(0, 0, 16'h0, 1);
        #12;
        check("reset", 16'h0000, 16'h0800, 16'h0000, 0, 0, 1);
        @(negedge clk);
        rst = 1'b1;

        tbl[0] = mk("fetch0", 0, 0, 0, 16'h02, 16'h4000, 16'h02, 1, 0);
        tbl[1] = mk("fetch1", 0, 0, 0, 16'h04, 16'h4100, 16'h04, 1, 0);
        tbl[2] = mk("fetch2", 0, 0, 0, 16'h06, 16'h4200, 16'h06, 1, 0);
        tbl[3] = mk("stall1", 1, 0, 0, 16'h06, 16'h4200, 16'h06, 1, 0);
        tbl[4] = mk("stall2", 1, 0, 0, 16'h06, 16'h4200, 16'h06, 1, 0);
        tbl[5] = mk("resume", 0, 0, 0, 16'h08, 16'h4300, 16'h08, 1, 0);
        tbl[6] = mk("br_stl", 1, 1, 16'h40, 16'h40, 16'h0800, 16'h0, 0, 0);
        tbl[7] = mk("tgt0", 0, 0, 0, 16'h42, 16'h6000, 16'h42, 1, 0);
        tbl[8] = mk("tgt1", 0, 0, 0, 16'h44, 16'h6100, 16'h44, 1, 0);

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].stall, tbl[i].br, tbl[i].tgt, 1);
            tick();
            check(tbl[i].nm, tbl[i].addr, tbl[i].instr, tbl[i].pcinc,
                  tbl[i].valid, tbl[i].hlt, tbl[i].valid);
        end

        do_reset("reset_w");
        drive(0, 0, 0, 1);
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0);
            tick();
            if (WAIT_EN)
                check("wait", 16'h4, 16'h0800, 0, 0, 0, 0);
            else
                check("nowait", 16'(6 + 2 * k), fw(16'(4 + 2 * k)),
                      16'(6 + 2 * k), 1, 0, 1);
        end
        drive(0, 0, 0, 1);
        tick();
        if (WAIT_EN)
            check("wait_end", 16'h6, fw(16'h4), 16'h6, 1, 0, 1);
        else
            check("nowait_end", 16'hC, fw(16'hA), 16'hC, 1, 0, 1);

        halt_on = 1; halt_addr = 16'h10;
        drive(0, 1, 16'h10, 1);
        tick();
        check("br_halt", 16'h10, 16'h0800, 0, 0, 0, 0);
        drive(0, 0, 0, 1);
        tick();
        check("halt_lat", 16'h12, 16'h0000, 16'h12, 1, 1, 1);
        drive(1, 0, 0, 1);
        tick();
        check("halt_stl", 16'h12, 16'h0000, 16'h12, 1, 1, 1);
        drive(0, 0, 0, 1);
        tick();
        check("halt_bub1", 16'h12, 16'h0800, 0, 0, 1, 0);
        tick();
        check("halt_bub2", 16'h12, 16'h0800, 0, 0, 1, 0);
        drive(0, 1, 16'h20, 1);
        tick();
        check("unhalt", 16'h20, 16'h0800, 0, 0, 0, 0);
        drive(0, 0, 0, 1);
        tick();
        check("unhalt_f", 16'h22, fw(16'h20), 16'h22, 1, 0, 1);
        halt_on = 0;

        drive(0, 1, 16'hFFFE, 1);
        tick();
        check("br_wrap", 16'hFFFE, 16'h0800, 0, 0, 0, 0);
        drive(0, 0, 0, 1);
        tick();
        check("wrap", 16'h0000, 16'hFFFF, 16'h0000, 1, 0, 1);

        drive(0, 1, 16'h30, 1);
        tick();
        drive(0, 0, 0, 1);
        tick();
        check("at30", 16'h32, fw(16'h30), 16'h32, 1, 0, 1);
        do_reset("async_rst");
        tick();
        check("restart", 16'h02, 16'h4000, 16'h02, 1, 0, 1);

        for (int i = 0; i < 256; i++) begin
            d = 16'($urandom);
            if ($urandom_range(0, 15) == 0) d[15:11] = 5'b0;
            else if (d[15:11] == 5'b0) d[15:11] = 5'b00001;
            rnd_mem[i] = d;
        end
        use_rnd = 1;
        do_reset("reset_r");
        m_pc = 16'h0; m_instr = 16'h0800; m_pcinc = 16'h0;
        m_valid = 0; m_halt = 0;
        for (int c = 0; c < 2000; c++) begin
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 9) == 0) ||
                (m_halt && $urandom_range(0, 3) == 0);
            t = {16'($urandom) & 16'hFFFE};
            r = ($urandom_range(0, 4) != 0);
            drive(s, b, t, r);
            if (b) begin
                m_pc = t; m_instr = 16'h0800; m_valid = 0; m_halt = 0;
            end else if (s) begin
            end else if (!(r || !WAIT_EN) || m_halt) begin
                m_instr = 16'h0800; m_valid = 0;
            end else begin
                d = rnd_mem[m_pc[8:1]];
                m_instr = d; m_pcinc = m_pc + 16'd2; m_valid = 1;
                m_pc = m_pc + 16'd2;
                if (d[15:11] == 5'b0) m_halt = 1;
            end
            tick();
            check("rand", m_pc, m_instr, m_pcinc, m_valid, m_halt, m_valid);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_ifid.md
# fetch_ifid

Instruction-fetch stage and IF/ID pipeline register of the 5-stage WISC pipeline. Holds the PC and drives the instruction-memory address. Latches each fetched instruction with its PC+2 into IF/ID. Obeys the hazard unit's stall, the EX/MEM branch redirect and an internal HALT freeze, and presents the IF/ID source-register fields that the hazard unit compares against ID/EX.

## Interface
Parameters:
- PC_W, 16, PC / instruction-address width
- RESET_PC, 16'h0000, PC value after reset

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- stallCtrl  in  1  hold request from hazard unit
- Branch_EXMEM  in  1  taken branch/jump resolved in EX/MEM
- target_EXMEM  in  PC_W  redirect address
- imem_addr  out  PC_W  fetch address (= current PC)
- imem_data  in  16  instruction word, combinational read of imem_addr
- imem_ready  in  1  fetch data valid (present only with FETCH_IMEM_WAIT_EN)
- instr_IFID  out  16  latched instruction
- pcInc_IFID  out  PC_W  latched PC+2
- valid_IFID  out  1  IF/ID holds a real instruction
- Rd1_IFID  out  3  instr_IFID[10:8]
- Rd2_IFID  out  3  instr_IFID[7:5]
- halted  out  1  HALT latched, fetch frozen

## Operation
Per-cycle priority, highest first: reset > redirect > stall > fetch wait > halt freeze > normal fetch.
- Redirect (Branch_EXMEM=1): PC <= target_EXMEM. IF/ID <= NOP (16'h0800), valid 0. halt_pending cleared. Redirect overrides a simultaneous stallCtrl.
- Stall (stallCtrl=1, no redirect): PC and all IF/ID contents hold unchanged.
- Fetch wait (imem_ready=0): PC holds. IF/ID <= NOP with valid 0, i.e. a bubble.
- Normal fetch: PC <= PC+2, wrapping modulo 2^PC_W. IF/ID <= {imem_data, PC+2}, valid 1.
- HALT detect: when an instruction with opcode imem_data[15:11]=5'b00000 is latched, halt_pending sets. While it is set, PC holds and IF/ID <= NOP with valid 0.
- halted mirrors halt_pending. Only a redirect or reset clears it, which cancels a speculatively fetched HALT.
- Rd1_IFID and Rd2_IFID are pure slices of instr_IFID.

State: PC, IF/ID {instr, pcInc, valid}, halt_pending.

## Timing
- Reset values: PC = RESET_PC, imem_addr = RESET_PC, instr_IFID = 16'h0800, pcInc_IFID = 0, valid_IFID = 0, halted = 0, Rd1/Rd2_IFID = 0.
- First valid IF/ID on the first rising edge after rst deasserts.
- Fetch latency: 1 cycle from imem_addr to instr_IFID.
- Redirect asserted in cycle N: imem_addr = target from N+1, first target instruction in IF/ID at N+2. IF/ID in N+1 is a bubble.
- Stall held k cycles: IF/ID is unchanged for k edges and no fetch is lost.
- HALT latched at edge E: halted = 1 after E. PC is frozen at HALT address + 2.
- Stall and HALT latched together: HALT remains in IF/ID and halt_pending stays set.
- PC = 16'hFFFE fetch: next PC = 16'h0000.
- Reset asserted mid-operation: all state returns immediately to reset values, with no clock edge needed.

## Configuration
- FETCH_IMEM_WAIT_EN defined: the imem_ready port exists and the fetch-wait rule is active.
- FETCH_IMEM_WAIT_EN undefined: the port is absent, imem_ready is treated as constant 1, and no wait bubbles are generated.

## Structure
- Shared package wisc_pkg holds:
  - NOP_INSTR (16'h0800)
  - HALT_OP (5'b00000)
  - REG_ADDR_W (3)
  - INSTR_W (16)
- Sub-module ifid_reg: the IF/ID register with hold (stall) and load-NOP (flush/bubble) controls, async active-low reset. The PC register and its next-PC mux stay in fetch_ifid.

## Test plan
- Reset release, imem returns 16'h4000, 16'h4100, … → instr_IFID follows one cycle later, pcInc_IFID = 2, 4, 6; imem_addr = 0, 2, 4.
- stallCtrl=1 for 2 cycles at PC=6 → imem_addr stays 6, instr_IFID/pcInc_IFID unchanged for 2 edges, then resume with PC=8.
- Branch_EXMEM=1 with target 16'h0040 while stallCtrl=1 → next imem_addr = 0x0040, instr_IFID = 16'h0800 with valid 0, then 0x0040's instruction with pcInc 0x0042.
- HALT (16'h0000) fetched at PC=0x10 → halted=1, imem_addr frozen at 0x12, IF/ID bubbles. Later Branch_EXMEM to 0x20 → halted=0, fetch resumes at 0x20.
- With FETCH_IMEM_WAIT_EN, imem_ready=0 for 3 cycles at PC=4 → 3 NOP bubbles with valid 0 and PC held. Without the macro the same stimulus fetches normally.
- rst pulsed low mid-stream at PC=0x30 → outputs return to reset values asynchronously, and fetch restarts at RESET_PC.
